alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor of the single-cycle CPU ALU: WIDTH-bit datapath, extended op set,
//  full NZCV-style flags and an iterative multiplier. Sits between register read / sign-extend and
//  writeback. Uses valid/ready handshakes on input and output, so the core can stall it or be stalled.
// PARAMETERS
//  WIDTH   32  datapath width in bits (>=8, power of 2); shift amount = data2[$clog2(WIDTH)-1:0]
//  MUL_EN  1   1: op 1001 is iterative MUL; 0: op 1001 is illegal, no multiplier logic
// PORTS
//  clk        in   1      rising-edge clock (sole clock)
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      block accepts op this cycle (transfer = in_valid & in_ready)
//  alu_op     in   4      opcode (see BEHAVIOUR)
//  data1      in   WIDTH  operand A
//  data2reg   in   WIDTH  operand B, register source
//  data2ext   in   WIDTH  operand B, sign-extended immediate source
//  mux        in   1      0: B=data2reg, 1: B=data2ext; sampled at transfer
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result (transfer = out_valid & out_ready)
//  result     out  WIDTH  registered result
//  zero       out  1      result==0
//  negative   out  1      result[WIDTH-1]
//  carry      out  1      ADD carry-out; SUB no-borrow (A>=B unsigned); MUL high half !=0; else 0
//  overflow   out  1      signed overflow for ADD/SUB; else 0
//  illegal    out  1      opcode undefined; result forced to 0, other flags from result
//  busy       out  1      multiplier FSM not IDLE
// BEHAVIOUR
//  - Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed,
//    result 1/0), 1000 SRA, 1001 MUL (low WIDTH bits, unsigned), 1100 NOR; all others illegal.
//  - Reset (rst_n=0 at posedge): out_valid=0, result=0, all flags=0, busy=0, S1 empty, FSM IDLE.
//    in_ready=0 during reset cycle. Reset mid-MUL aborts; no result is ever emitted for it.
//  - Two registers: S1 (issue: op, A, selected B) and S2 (result+flags, drives outputs).
//  - in_ready = !S1.valid | s1_advance. s1_advance = S1 op complete & (!out_valid | out_ready).
//  - Single-cycle ops: accepted at edge N into S1, complete in S1 combinationally, written to S2 at
//    edge N+1 -> out_valid high after N+1. Back-to-back throughput 1 op/cycle with out_ready=1.
//  - MUL: FSM IDLE->MUL on S1 holding MUL; shift-add one bit/cycle for WIDTH cycles (count 0..WIDTH-1);
//    MUL->DONE at count WIDTH-1; DONE->IDLE when S2 accepts. Accepted at edge N -> out_valid after
//    edge N+WIDTH+1 (no stall). in_ready=0 while S1 holds an unfinished MUL.
//  - Backpressure: out_valid & !out_ready holds S2 (result and flags stable); S1 then holds; in_ready
//    falls once S1 full. No op is lost or duplicated.
//  - Simultaneous: out transfer and S1 advance same edge -> S2 reloads, out_valid stays 1.
//  - Arithmetic: ADD/SUB on WIDTH+1 bits for carry; overflow = (A,B' same sign) & result sign differs,
//    B'=~B for SUB. Shifts by data2[$clog2(WIDTH)-1:0] only; upper bits ignored. Wrap-around modulo 2^WIDTH.
// STRUCTURE
//  - Package alu_pkg: opcode localparams (ALU_AND..ALU_NOR), mul FSM state enum {IDLE,MUL,DONE},
//    flag struct {zero,negative,carry,overflow,illegal}.
//  - Sub-module alu_mul_iter: shift-add multiplier, start/done handshake, WIDTH param, own counter;
//    generated only when MUL_EN=1. Top holds S1/S2, op decode, single-cycle datapath, handshakes.
// TESTING
//  - Reset: hold rst_n=0 2 cycles mid-stream -> out_valid=0, result=0, flags=0, in_ready=0 then 1.
//  - ADD 0x7FFFFFFF+0x1 (mux=0) -> result 0x80000000, N=1, V=1, C=0, Z=0, out_valid 2 edges after accept.
//  - SUB 0xF-0xF via data2ext (mux=1) -> result 0, Z=1, C=1, V=0; SLT 0xFFFFFFFF,0x1 -> result 1.
//  - Stream AND,OR,XOR,SRA(0x80000000,>>4 => 0xF8000000) with out_ready=1 -> one result per cycle, in order.
//  - MUL 0x10000*0x10000 -> result 0, C=1, Z=1, busy for 32 cycles, in_ready=0 meanwhile; out at N+33.
//  - Backpressure: out_ready=0 for 5 cycles with 3 ops offered -> S2 stable, 2 ops held, none lost;
//    illegal op 1111 -> result 0, illegal=1, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, multiplier FSM states
// and the flag bundle carried from the issue stage to the output register.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_MUL  = 2'd1;
    localparam logic [1:0] MS_DONE = 2'd2;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (sync, active-low), start (latch a/b and begin),
// ack (result consumed), a/b operands, busy (not idle), done, prod (2*WIDTH).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ack,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MS_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            // start only arrives when the previous product has been taken
            state  <= MS_MUL;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else begin
            case (state)
                MS_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= MS_DONE;
                end
                MS_DONE: begin
                    if (ack) state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

    assign busy = (state != MS_IDLE);
    assign done = (state == MS_DONE);
    assign prod = acc;

endmodule

// File: rtl/alu_pipe.sv
// Two-register pipelined ALU with valid/ready on both sides and NZCV flags.
// Ports: clk, rst_n, in_valid/in_ready, alu_op, data1, data2reg, data2ext, mux,
// out_valid/out_ready, result, zero, negative, carry, overflow, illegal, busy.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2reg,
    input  logic [WIDTH-1:0] data2ext,
    input  logic             mux,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    logic               s1_valid;
    logic [3:0]         s1_op;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic               s1_is_mul;
    logic               s1_done;
    logic               s1_advance;
    logic               accept;
    logic               mul_done;
    logic               mul_busy;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SW-1:0]      sh;
    alu_flags_t         flg;
    alu_flags_t         s2_flags;

    assign s1_is_mul  = MUL_EN && (s1_op == ALU_MUL);
    assign s1_done    = !s1_is_mul || mul_done;
    assign s1_advance = s1_valid && s1_done && (!out_valid || out_ready);
    assign in_ready   = rst_n && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= alu_op;
            s1_a     <= data1;
            s1_b     <= mux ? data2ext : data2reg;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Carry on SUB is the no-borrow bit of A + ~B + 1.
    always_comb begin
        sh   = s1_b[SW-1:0];
        sum  = {1'b0, s1_a} + {1'b0, s1_b};
        diff = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH + 1)'(1);
        res  = '0;
        flg  = '0;
        case (s1_op)
            ALU_AND: res = s1_a & s1_b;
            ALU_OR:  res = s1_a | s1_b;
            ALU_XOR: res = s1_a ^ s1_b;
            ALU_NOR: res = ~(s1_a | s1_b);
            ALU_SLL: res = s1_a << sh;
            ALU_SRL: res = s1_a >> sh;
            ALU_SRA: res = $signed(s1_a) >>> sh;
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            ALU_ADD: begin
                res          = sum[WIDTH-1:0];
                flg.carry    = sum[WIDTH];
                flg.overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                               (res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            ALU_SUB: begin
                res          = diff[WIDTH-1:0];
                flg.carry    = diff[WIDTH];
                flg.overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                               (res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            ALU_MUL: begin
                if (MUL_EN) begin
                    res       = prod[WIDTH-1:0];
                    flg.carry = |prod[2*WIDTH-1:WIDTH];
                end else begin
                    flg.illegal = 1'b1;
                end
            end
            default: flg.illegal = 1'b1;
        endcase
        flg.zero     = (res == '0);
        flg.negative = res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            s2_flags  <= '0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            result    <= res;
            s2_flags  <= flg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign zero     = s2_flags.zero;
    assign negative = s2_flags.negative;
    assign carry    = s2_flags.carry;
    assign overflow = s2_flags.overflow;
    assign illegal  = s2_flags.illegal;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk   (clk),
                .rst_n (rst_n),
                .start (accept && (alu_op == ALU_MUL)),
                .ack   (s1_advance),
                .a     (data1),
                .b     (mux ? data2ext : data2reg),
                .busy  (mul_busy),
                .done  (mul_done),
                .prod  (prod)
            );
        end else begin : g_nomul
            assign mul_busy = 1'b0;
            assign mul_done = 1'b0;
            assign prod     = '0;
        end
    endgenerate

    assign busy = mul_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases then a random
// stream with random backpressure, checked against an arithmetic model.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] data1;
    logic [31:0] data2reg;
    logic [31:0] data2ext;
    logic        mux;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        illegal;
    logic        busy;

    typedef struct packed {
        logic [31:0] r;
        logic z;
        logic n;
        logic c;
        logic v;
        logic ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   mode   = 0;

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .data1(data1), .data2reg(data2reg),
        .data2ext(data2ext), .mux(mux), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow),
        .illegal(illegal), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      s;
        logic [63:0] w;
        int unsigned amt;
        e   = '0;
        sa  = $signed(a);
        sbv = $signed(b);
        amt = b % 32;
        case (op)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd3:  e.r = a ^ b;
            4'd12: e.r = ~(a | b);
            4'd4:  e.r = a << amt;
            4'd5:  e.r = a >> amt;
            4'd8: begin
                s   = sa >>> amt;
                e.r = s[31:0];
            end
            4'd7:  e.r = (sa < sbv) ? 32'd1 : 32'd0;
            4'd2: begin
                w   = {32'd0, a} + {32'd0, b};
                e.r = w[31:0];
                e.c = w[32];
                s   = sa + sbv;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                e.r = a - b;
                e.c = (a >= b);
                s   = sa - sbv;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd9: begin
                w   = {32'd0, a} * {32'd0, b};
                e.r = w[31:0];
                e.c = (w[63:32] != 0);
            end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.r == 0);
        e.n = e.r[31];
        return e;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] r, input logic [31:0] x,
                              input logic m);
        in_valid = 1'b1;
        alu_op   = op;
        data1    = a;
        data2reg = r;
        data2ext = x;
        mux      = m;
    endtask

    task automatic wait_accept(output int waits);
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits >= 200) begin
                chk("accept_timeout", 64'd1, 64'd0);
                return;
            end
        end
        sb.push_back(model(alu_op, data1, mux ? data2ext : data2reg));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_out(input string name, input int expk);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 100);
        chk(name, 64'(k), 64'(expk));
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // monitor: pops one expectation per output transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {32'd0, result}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("result", {27'd0, result, zero, negative, carry,
                                   overflow, illegal}, {27'd0, e});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w;
        int   tot;
        int   k;
        int   bad;
        exp_t e1;
        rst_n = 1'b0;
        mode  = 0;
        idle();
        alu_op = 4'd0; data1 = '0; data2reg = '0; data2ext = '0; mux = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_state", {out_valid, result, zero, negative, carry, overflow,
                          illegal, busy, in_ready}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);

        // ADD overflow; out_valid first seen at the 2nd negedge after accept
        step();
        set_inputs(4'd2, 32'h7FFF_FFFF, 32'h1, 32'h5555, 1'b0);
        wait_accept(w);
        step();
        idle();
        wait_out("add_latency", 2);
        drain();

        // SUB via immediate, then SLT signed
        step();
        set_inputs(4'd6, 32'hF, 32'h1234, 32'hF, 1'b1);
        wait_accept(w);
        step();
        set_inputs(4'd7, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        wait_accept(w);
        step();
        idle();
        drain();

        // back-to-back stream: in_ready never drops
        step();
        tot = 0;
        set_inputs(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 1'b0);
        wait_accept(w); tot += w; step();
        set_inputs(4'd1, 32'hF000_0000, 32'h0000_000F, 32'h0, 1'b0);
        wait_accept(w); tot += w; step();
        set_inputs(4'd3, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0, 1'b0);
        wait_accept(w); tot += w; step();
        set_inputs(4'd8, 32'h8000_0000, 32'h4, 32'h0, 1'b0);
        wait_accept(w); tot += w; step();
        idle();
        chk("stream_rate", 64'(tot), 64'd0);
        drain();

        // MUL: busy and stalled input for 32 negedges, result at the 34th
        step();
        set_inputs(4'd9, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);
        wait_accept(w);
        step();
        idle();
        k   = 0;
        bad = 0;
        do begin
            @(negedge clk);
            k++;
            if (k <= 32 && !(busy && !in_ready)) bad++;
        end while (!out_valid && k < 100);
        chk("mul_latency", 64'(k), 64'd34);
        chk("mul_busy_stall", 64'(bad), 64'd0);
        drain();

        // backpressure: two ops held, third waits, illegal op last
        mode = 2;
        step();
        step();
        e1 = model(4'd2, 32'd5, 32'd7);
        set_inputs(4'd2, 32'd5, 32'd7, 32'h0, 1'b0);
        wait_accept(w);
        step();
        set_inputs(4'd3, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 1'b0);
        wait_accept(w);
        step();
        set_inputs(4'd15, 32'h1, 32'h2, 32'h3, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {in_ready, out_valid, result},
                {1'b0, 1'b1, e1.r});
        end
        mode = 0;
        wait_accept(w);
        step();
        idle();
        drain();

        // random stream with random backpressure
        mode = 1;
        step();
        repeat (300) begin
            set_inputs(4'($urandom_range(0, 15)), rnd(), rnd(), rnd(),
                       1'($urandom_range(0, 1)));
            wait_accept(w);
            step();
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step();
            end
        end
        idle();
        mode = 0;
        drain();

        // reset in the middle of a multiply: nothing may come out
        step();
        set_inputs(4'd9, $urandom(), $urandom(), 32'h0, 1'b0);
        wait_accept(w);
        step();
        idle();
        repeat (5) @(negedge clk);
        chk("busy_mid_mul", busy, 1);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_state", {out_valid, result, zero, negative, carry,
                              overflow, illegal, busy, in_ready}, 64'd0);
        step();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_ready", {in_ready, busy}, 64'b10);
        repeat (40) @(negedge clk);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
